// File: rtl/wtime_pkg.sv
// Shared widths and FSM state encoding for the waiting-time table writer.
// Widths here are for the default N; the top recomputes them from its own parameters.
package wtime_pkg;
   localparam int N_DEF    = 3;
   localparam int MULT_DEF = 3;
   localparam int AW       = N_DEF + 2;
   localparam int DW       = N_DEF + 2;
   localparam int NUMW     = N_DEF + 3;
   localparam int DEPTH    = 2 ** (N_DEF + 2);

   typedef enum logic [2:0] {IDLE, LOAD, DIV, WRITE, DONE} state_t;
endpackage

// File: rtl/wtime_divider.sv
// Sequential restoring divider: NUM_W-bit numerator by 2-bit divisor, one quotient bit per cycle.
// quot carries the final quotient during the cycle rdy is high.
module wtime_divider
   import wtime_pkg::*;
#(
   parameter int NUM_W = NUMW
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [NUM_W-1:0] num,
   input  logic [1:0]       den,
   output logic [NUM_W-1:0] quot,
   output logic             rdy
);
   localparam int CW = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] r_q;
   logic [1:0]       r_rem;
   logic [1:0]       r_den;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       w_shift;
   logic             w_ge;
   logic [1:0]       w_rem_next;

   // The remainder is always below the divisor (at most 2), so 2 bits suffice.
   assign w_shift    = {r_rem, r_q[NUM_W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_den});
   assign w_rem_next = w_ge ? (w_shift[1:0] - r_den) : w_shift[1:0];
   assign quot       = {r_q[NUM_W-2:0], w_ge};
   assign rdy        = (r_cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= '0;
         r_rem <= '0;
         r_den <= '0;
         r_cnt <= '0;
      end else if (go) begin
         r_q   <= num;
         r_rem <= '0;
         r_den <= den;
         r_cnt <= CW'(NUM_W);
      end else if (r_cnt != '0) begin
         r_q   <= quot;
         r_rem <= w_rem_next;
         r_cnt <= r_cnt - CW'(1);
      end
   end
endmodule

// File: rtl/wtime_table_writer.sv
// Walks every {t, p} address once per start and writes floor(MULT*(p+t-1)/t)
// into the waiting-time memory; t==0 entries are written as 0 without dividing.
module wtime_table_writer
   import wtime_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int MULT = MULT_DEF
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         we,
   output logic [N+1:0] waddr,
   output logic [N+1:0] wdata
);
   localparam int A_W   = N + 2;
   localparam int NUM_W = N + 3;

   state_t           r_state;
   logic [A_W-1:0]   r_addr;
   logic [A_W-1:0]   r_waddr;
   logic [A_W-1:0]   r_wdata;
   logic             r_busy;
   logic             r_done;
   logic             r_we;

   logic [1:0]       w_t;
   logic [N-1:0]     w_p;
   logic [NUM_W-1:0] w_num;
   logic [NUM_W-1:0] w_quot;
   logic             w_go;
   logic             w_rdy;
   logic             w_quot_msb_unused;

   assign w_t   = r_addr[A_W-1:N];
   assign w_p   = r_addr[N-1:0];
   assign w_num = NUM_W'(MULT * (int'(w_p) + int'(w_t) - 1));
   assign w_go  = (r_state == LOAD) && (w_t != 2'd0);
   // Quotient never exceeds MULT*(2**N-1), so its top bit is always zero.
   assign w_quot_msb_unused = w_quot[NUM_W-1];

   wtime_divider #(.NUM_W(NUM_W)) u_div (
      .clk  (clk),
      .rst  (rst),
      .go   (w_go),
      .num  (w_num),
      .den  (w_t),
      .quot (w_quot),
      .rdy  (w_rdy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state <= LOAD;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            LOAD: begin
               if (w_t == 2'd0) begin
                  r_we    <= 1'b1;
                  r_waddr <= r_addr;
                  r_wdata <= '0;
                  r_state <= WRITE;
               end else begin
                  r_state <= DIV;
               end
            end
            DIV: begin
               if (w_rdy) begin
                  r_we    <= 1'b1;
                  r_waddr <= r_addr;
                  r_wdata <= w_quot[A_W-1:0];
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               r_we <= 1'b0;
               if (r_addr == {A_W{1'b1}}) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_addr  <= r_addr + A_W'(1);
                  r_state <= LOAD;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;
endmodule

// File: tb/tb_wtime_table_writer.sv
// Directed bench for the waiting-time table writer (N=3, MULT=3): scoreboarded
// writes plus timing, restart, abort and reset-priority checks.
module tb_wtime_table_writer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, we;
   logic [4:0] waddr, wdata;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int wcount = 0;
   int cap_cyc [32];

   typedef struct {int addr; int data;} exp_t;
   exp_t exp_q [$];

   wtime_table_writer #(.N(3), .MULT(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input int a);
      int t, p;
      t = a / 8;
      p = a % 8;
      if (t == 0) return 0;
      return (3 * (p + t - 1)) / t;
   endfunction

   task automatic push_entries(input int n);
      exp_t e;
      for (int a = 0; a < n; a++) begin
         e.addr = a;
         e.data = model(a);
         exp_q.push_back(e);
      end
   endtask

   // Returns the index of the edge at which start was sampled (LOAD entry).
   task automatic pulse_start(output int load);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      load = cyc;
   endtask

   task automatic wait_done(output int dcyc, output int ok);
      ok = 0;
      dcyc = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            dcyc = cyc;
            return;
         end
      end
   endtask

   // Scoreboard: every write must match the next queued expectation.
   always @(negedge clk) begin
      if (we) begin
         exp_t e;
         if (waddr < 32) cap_cyc[waddr] = cyc + 1;
         wcount++;
         if (exp_q.size() == 0) begin
            chk("unexpected_we", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("waddr#%0d", e.addr), int'(waddr), e.addr);
            chk($sformatf("wdata@%0d", e.addr), int'(wdata), e.data);
         end
      end
   end

   initial begin
      int load, dcyc, ok;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_we", int'(we), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_wdata", int'(wdata), 0);

      // Pass 1: undisturbed full pass with timing checks.
      wcount = 0;
      push_entries(32);
      pulse_start(load);
      chk("p1_busy_after_start", int'(busy), 1);
      wait_done(dcyc, ok);
      chk("p1_done_seen", ok, 1);
      chk("p1_done_cycle", dcyc - load, 208);
      chk("p1_busy_at_done", int'(busy), 0);
      chk("p1_first_we", cap_cyc[0] - load, 2);
      chk("p1_addr8_len", cap_cyc[8] - cap_cyc[7], 8);
      chk("p1_last_we", cap_cyc[31] - load, 208);
      repeat (3) @(negedge clk);
      chk("p1_done_held", int'(done), 1);
      chk("p1_wcount", wcount, 32);
      chk("p1_queue_empty", exp_q.size(), 0);

      // Pass 2: start from DONE, with a stray start during DIV of addr 10.
      wcount = 0;
      push_entries(32);
      pulse_start(load);
      chk("p2_done_cleared", int'(done), 0);
      chk("p2_busy_set", int'(busy), 1);
      repeat (34) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(dcyc, ok);
      chk("p2_done_seen", ok, 1);
      chk("p2_done_cycle", dcyc - load, 208);
      repeat (2) @(negedge clk);
      chk("p2_wcount", wcount, 32);
      chk("p2_queue_empty", exp_q.size(), 0);

      // Pass 3: reset during DIV of addr 20 aborts after 20 writes.
      wcount = 0;
      push_entries(20);
      pulse_start(load);
      repeat (114) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_we", int'(we), 0);
      chk("abort_waddr", int'(waddr), 0);
      chk("abort_wdata", int'(wdata), 0);
      repeat (40) @(negedge clk);
      chk("abort_wcount", wcount, 20);
      chk("abort_busy_idle", int'(busy), 0);
      chk("abort_queue_empty", exp_q.size(), 0);

      // rst and start on the same edge: reset wins, block stays idle.
      wcount = 0;
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("rs_busy", int'(busy), 0);
      chk("rs_done", int'(done), 0);
      chk("rs_we", int'(we), 0);
      chk("rs_waddr", int'(waddr), 0);
      chk("rs_wcount", wcount, 0);

      // Pass 4: fresh start from IDLE restarts at address 0.
      wcount = 0;
      push_entries(32);
      pulse_start(load);
      wait_done(dcyc, ok);
      chk("p4_done_seen", ok, 1);
      chk("p4_done_cycle", dcyc - load, 208);
      chk("p4_first_we", cap_cyc[0] - load, 2);
      repeat (2) @(negedge clk);
      chk("p4_wcount", wcount, 32);
      chk("p4_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wtime_table_writer.md
Name: wtime_table_writer

Overview:
Fills the waiting-time lookup memory for the bank-queue manager. The memory is addressed by {tcount, pcount}.
- On a start pulse, the block walks every address once.
- For each address it computes wtime = 3*(p+t-1)/t, using a multi-cycle restoring divider.
- It issues one write per address on a simple write port.
- It sits between system init and the waiting-time memory's write side, so table contents are produced in hardware instead of preloaded.

Parameters:
N, 3, pcount width; address and data width are N+2, table depth is 2**(N+2).
MULT, 3, per-customer service-time constant (numerator multiplier); must satisfy MULT*(2**N+1) < 2**(N+3).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to (re)build the table; sampled only in IDLE or DONE
busy  output  1  high from the cycle after start is accepted until the last write completes
done  output  1  high after a full table pass; held until the next accepted start or rst
we  output  1  write enable, one-cycle pulse per table entry
waddr  output  N+2  write address = {t[1:0], p[N-1:0]}
wdata  output  N+2  waiting time for waddr, valid when we=1

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE; busy=0, done=0, we=0, waddr=0, wdata=0; divider cleared. Reset mid-pass aborts with no further writes; the partially written table is left as-is.
- States:
  - IDLE: wait for start.
  - LOAD: decode t=addr[N+1:N], p=addr[N-1:0]. If t==0, set wdata=0 and go to WRITE. Otherwise set numerator=MULT*(p+t-1) (N+3 bits), latch divisor t (2 bits), and go to DIV.
  - DIV: restoring division, one quotient bit per cycle, exactly N+3 cycles, MSB first.
  - WRITE: we=1 for one cycle with waddr=addr and wdata=quotient[N+1:0]. If addr is the last entry (all ones), go to DONE; otherwise increment addr and go to LOAD.
  - DONE: done=1, busy=0. A start returns the block to LOAD with addr=0 and done cleared.
- Start from IDLE or DONE: the accepted start edge moves the FSM to LOAD with addr=0, busy=1.
- start while busy: ignored; no restart and no error.
- Cycles per entry: t==0 takes 2 (LOAD, WRITE). t!=0 takes N+5 (LOAD, N+3 DIV, WRITE).
- Pass length for N=3: 8*2 + 24*8 = 208 cycles from the first LOAD to the last WRITE. done rises on the edge after the last WRITE.
- Arithmetic:
  - Quotient truncates (floor).
  - Remainder is discarded.
  - Quotient always fits N+2 bits; the maximum is MULT*(2**N-1) when t=1.
  - No division by zero occurs; t==0 never enters DIV.
- Writes go in strictly ascending address order, each address exactly once per pass.
- we is never high outside WRITE; waddr and wdata hold their last values when we=0.
- Simultaneous rst and start: rst wins.

Decomposition:
- Package wtime_pkg holds:
  - N default and MULT;
  - localparams AW=N+2, DW=N+2, NUMW=N+3, DEPTH=2**(N+2);
  - state enum {IDLE, LOAD, DIV, WRITE, DONE}.
- One sub-module, wtime_divider: NUMW-bit by 2-bit sequential restoring divider with ports clk, rst, go, num, den, quot, rdy.
  - rdy pulses in the last DIV cycle.
  - The FSM advances on rdy.

Test Plan:
- Reset then start (N=3): 32 we pulses, addresses 0..31 ascending. Addresses 0..7 write 0; addr 15 (t=1,p=7) writes 21; addr 16 (t=2,p=0) writes 1; addr 24 (t=3,p=0) writes 2; addr 31 (t=3,p=7) writes 9. Check every entry against floor(3*(p+t-1)/t).
- Timing: first we exactly 2 cycles after LOAD entry for addr 0. Entry addr 8 takes 8 cycles. The last we is 208 cycles after the first LOAD. done=1 and busy=0 on the following edge.
- start pulsed during DIV of addr 10: no restart, still exactly 32 writes, done asserts at the same cycle as the undisturbed pass.
- rst asserted during addr 20's DIV: next edge gives busy=0, done=0, we=0, waddr=0. No writes until a new start, which restarts at addr 0.
- start while in DONE: done drops to 0 on the next edge, busy=1, the full 32-entry pass repeats with identical data.
- rst and start high on the same edge: block stays in IDLE with all outputs 0.
